// File: rtl/idx_oh_pointer_pkg.sv
// Shared definitions for the index/one-hot pointer: direction names and the
// resolved command type used inside the pointer.
package idx_oh_pointer_pkg;

    localparam string DIR_LSB0 = "LSB0";
    localparam string DIR_MSB0 = "MSB0";

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_LOAD,
        CMD_ADVANCE
    } idx_oh_cmd_t;

endpackage

// File: rtl/oh_next_masked.sv
// Combinational cyclic search for the next set mask bit after cur_index.
// The current position is examined last, so a mask holding only the current
// bit selects the current index again. Used when IDX_OH_POINTER_MASK_EN is set.
module oh_next_masked #(
    parameter int NUM_SIGNALS = 8,
    parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [INDEX_WIDTH-1:0] cur_index,
    input  logic [NUM_SIGNALS-1:0] mask,
    output logic [INDEX_WIDTH-1:0] next_index,
    output logic                   found,
    output logic                   wrap
);

    // Walk the positions cur+1 .. cur+NUM_SIGNALS (mod NUM_SIGNALS) and keep the first hit
    always_comb begin
        int cand;
        cand       = 0;
        next_index = cur_index;
        found      = 1'b0;
        for (int k = 1; k <= NUM_SIGNALS; k++) begin
            cand = (int'(cur_index) + k) % NUM_SIGNALS;
            if (!found && mask[cand]) begin
                found      = 1'b1;
                next_index = INDEX_WIDTH'(cand);
            end
        end
        wrap = found && (next_index < cur_index);
    end

endmodule

// File: rtl/idx_oh_pointer.sv
// Registered round-robin pointer presenting a binary index and a one-hot copy.
// Optional feature: define IDX_OH_POINTER_MASK_EN to add advance_mask, which
// makes an advance skip to the next enabled index instead of index+1.
module idx_oh_pointer
    import idx_oh_pointer_pkg::*;
#(
    parameter int    NUM_SIGNALS = 8,
    parameter string DIRECTION   = "LSB0",
    parameter int    INDEX_WIDTH = $clog2(NUM_SIGNALS),
    parameter int    RESET_INDEX = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_en,
    input  logic [INDEX_WIDTH-1:0] load_index,
    input  logic                   advance_en,
`ifdef IDX_OH_POINTER_MASK_EN
    input  logic [NUM_SIGNALS-1:0] advance_mask,
`endif
    output logic [INDEX_WIDTH-1:0] index,
    output logic [NUM_SIGNALS-1:0] one_hot,
    output logic                   wrapped,
    output logic                   load_error
);

    localparam bit IS_MSB0 = (DIRECTION == DIR_MSB0);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_SIGNALS - 1);
    localparam logic [INDEX_WIDTH:0]   NUM_WIDE   = (INDEX_WIDTH + 1)'(NUM_SIGNALS);

    function automatic logic [NUM_SIGNALS-1:0] decode(input logic [INDEX_WIDTH-1:0] idx);
        logic [NUM_SIGNALS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (int'(idx) == i) begin
                oh[IS_MSB0 ? (NUM_SIGNALS - 1 - i) : i] = 1'b1;
            end
        end
        return oh;
    endfunction

    idx_oh_cmd_t            cmd;
    logic [INDEX_WIDTH-1:0] index_next;
    logic                   wrapped_next;
    logic                   load_error_next;
    logic [INDEX_WIDTH:0]   index_inc;

    assign index_inc = {1'b0, index} + (INDEX_WIDTH + 1)'(1);

`ifdef IDX_OH_POINTER_MASK_EN
    logic [INDEX_WIDTH-1:0] masked_index;
    logic                   masked_found;
    logic                   masked_wrap;

    oh_next_masked #(
        .NUM_SIGNALS(NUM_SIGNALS),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_next (
        .cur_index (index),
        .mask      (advance_mask),
        .next_index(masked_index),
        .found     (masked_found),
        .wrap      (masked_wrap)
    );
`endif

    // Resolve the two command strobes into one command; load has priority
    always_comb begin
        cmd = CMD_IDLE;
        if (load_en) begin
            cmd = CMD_LOAD;
        end else if (advance_en) begin
            cmd = CMD_ADVANCE;
        end
    end

    // Compute the next pointer state and its one-cycle status pulses
    always_comb begin
        index_next      = index;
        wrapped_next    = 1'b0;
        load_error_next = 1'b0;
        case (cmd)
            CMD_LOAD: begin
                if ({1'b0, load_index} < NUM_WIDE) begin
                    index_next = load_index;
                end else begin
                    load_error_next = 1'b1;
                end
            end
            CMD_ADVANCE: begin
`ifdef IDX_OH_POINTER_MASK_EN
                if (masked_found) begin
                    index_next   = masked_index;
                    wrapped_next = masked_wrap;
                end
`else
                if (index == LAST_INDEX) begin
                    index_next   = '0;
                    wrapped_next = 1'b1;
                end else begin
                    index_next = index_inc[INDEX_WIDTH-1:0];
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Register index, its one-hot form and the status pulses on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index      <= INDEX_WIDTH'(RESET_INDEX);
            one_hot    <= decode(INDEX_WIDTH'(RESET_INDEX));
            wrapped    <= 1'b0;
            load_error <= 1'b0;
        end else begin
            index      <= index_next;
            one_hot    <= decode(index_next);
            wrapped    <= wrapped_next;
            load_error <= load_error_next;
        end
    end

endmodule

// File: tb/tb_idx_oh_pointer.sv
// Self-checking bench for idx_oh_pointer: three instances (5/LSB0/reset 2,
// 8/MSB0/reset 0, 2/LSB0/reset 1) checked every cycle against a reference
// model, plus hand-computed directed expectations.
module tb_idx_oh_pointer;

    localparam int NINST = 3;
    localparam int N_TAB  [NINST] = '{5, 8, 2};
    localparam int MSB_TAB[NINST] = '{0, 1, 0};
    localparam int RI_TAB [NINST] = '{2, 0, 1};
    localparam int IW_TAB [NINST] = '{3, 3, 1};

    logic       clk;
    logic       reset_n;
    logic       le   [NINST];
    logic       ae   [NINST];
    logic [2:0] li   [NINST];
    logic [7:0] mask [NINST];

    logic [2:0] o_idx [NINST];
    logic [7:0] o_oh  [NINST];
    logic       o_wr  [NINST];
    logic       o_le  [NINST];

    logic [2:0] idx0, idx1;
    logic [0:0] idx2;
    logic [4:0] oh0;
    logic [7:0] oh1;
    logic [1:0] oh2;

    int n_cmp = 0;
    int n_bad = 0;

    int m_idx [NINST];
    int m_wr  [NINST];
    int m_le  [NINST];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    idx_oh_pointer #(.NUM_SIGNALS(5), .DIRECTION("LSB0"), .RESET_INDEX(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_en(le[0]), .load_index(li[0][2:0]),
        .advance_en(ae[0]),
`ifdef IDX_OH_POINTER_MASK_EN
        .advance_mask(mask[0][4:0]),
`endif
        .index(idx0), .one_hot(oh0), .wrapped(o_wr[0]), .load_error(o_le[0]));

    idx_oh_pointer #(.NUM_SIGNALS(8), .DIRECTION("MSB0"), .RESET_INDEX(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_en(le[1]), .load_index(li[1][2:0]),
        .advance_en(ae[1]),
`ifdef IDX_OH_POINTER_MASK_EN
        .advance_mask(mask[1]),
`endif
        .index(idx1), .one_hot(oh1), .wrapped(o_wr[1]), .load_error(o_le[1]));

    idx_oh_pointer #(.NUM_SIGNALS(2), .DIRECTION("LSB0"), .RESET_INDEX(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .load_en(le[2]), .load_index(li[2][0:0]),
        .advance_en(ae[2]),
`ifdef IDX_OH_POINTER_MASK_EN
        .advance_mask(mask[2][1:0]),
`endif
        .index(idx2), .one_hot(oh2), .wrapped(o_wr[2]), .load_error(o_le[2]));

    assign o_idx[0] = idx0;
    assign o_idx[1] = idx1;
    assign o_idx[2] = {2'b00, idx2};
    assign o_oh[0]  = {3'b000, oh0};
    assign o_oh[1]  = oh1;
    assign o_oh[2]  = {6'b000000, oh2};

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected one-hot bit pattern for an index under an instance's ordering
    function automatic int model_oh(input int k, input int idx);
        return 1 << (MSB_TAB[k] != 0 ? N_TAB[k] - 1 - idx : idx);
    endfunction

    // Where an advance from cur lands; -1 means the pointer holds
    function automatic int model_adv(input int k, input int cur);
`ifdef IDX_OH_POINTER_MASK_EN
        for (int s = 1; s <= N_TAB[k]; s++) begin
            int c;
            c = (cur + s) % N_TAB[k];
            if (mask[k][c]) return c;
        end
        return -1;
`else
        return (cur + 1) % N_TAB[k];
`endif
    endfunction

    // Reference model: one update per rising edge, reset asynchronously
    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < NINST; k++) begin
            if (!reset_n) begin
                m_idx[k] = RI_TAB[k];
                m_wr[k]  = 0;
                m_le[k]  = 0;
            end else begin
                int ld;
                int nx;
                ld = int'(li[k]) % (1 << IW_TAB[k]);
                m_wr[k] = 0;
                m_le[k] = 0;
                if (le[k]) begin
                    if (ld < N_TAB[k]) m_idx[k] = ld;
                    else m_le[k] = 1;
                end else if (ae[k]) begin
                    nx = model_adv(k, m_idx[k]);
                    if (nx >= 0) begin
                        m_wr[k]  = (nx < m_idx[k]) ? 1 : 0;
                        m_idx[k] = nx;
                    end
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        for (int k = 0; k < NINST; k++) begin
            checkOutput($sformatf("model_index[%0d]", k), int'(o_idx[k]), m_idx[k]);
            checkOutput($sformatf("model_one_hot[%0d]", k), int'(o_oh[k]), model_oh(k, m_idx[k]));
            checkOutput($sformatf("model_wrapped[%0d]", k), int'(o_wr[k]), m_wr[k]);
            checkOutput($sformatf("model_load_error[%0d]", k), int'(o_le[k]), m_le[k]);
            checkOutput($sformatf("popcount[%0d]", k), $countones(o_oh[k]), 1);
        end
    end

    // Drive one instance for one cycle (others idle), return at the next falling edge
    task automatic applyStimulus(input int k, input logic l, input logic a, input logic [2:0] idx);
        for (int j = 0; j < NINST; j++) begin
            le[j] = 1'b0;
            ae[j] = 1'b0;
            li[j] = 3'd0;
        end
        le[k] = l;
        ae[k] = a;
        li[k] = idx;
        @(negedge clk);
    endtask

    task automatic expectState(input string name, input int k, input int idx, input int oh,
                               input int wr, input int lerr);
        checkOutput({name, "_index"}, int'(o_idx[k]), idx);
        checkOutput({name, "_one_hot"}, int'(o_oh[k]), oh);
        checkOutput({name, "_wrapped"}, int'(o_wr[k]), wr);
        checkOutput({name, "_load_error"}, int'(o_le[k]), lerr);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int j = 0; j < NINST; j++) begin
            le[j] = 1'b0; ae[j] = 1'b0; li[j] = 3'd0; mask[j] = 8'hFF;
        end
        repeat (2) @(negedge clk);
        expectState("rst5", 0, 2, 5'b00100, 0, 0);
        expectState("rst8", 1, 0, 8'h80, 0, 0);
        expectState("rst2", 2, 1, 2'b10, 0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 1, 0, 3'd3); expectState("ld3", 0, 3, 5'b01000, 0, 0);
        applyStimulus(0, 0, 1, 3'd0); expectState("adv1", 0, 4, 5'b10000, 0, 0);
        applyStimulus(0, 0, 1, 3'd0); expectState("adv2", 0, 0, 5'b00001, 1, 0);
        applyStimulus(0, 0, 1, 3'd0); expectState("adv3", 0, 1, 5'b00010, 0, 0);
        applyStimulus(0, 1, 0, 3'd6); expectState("ld6", 0, 1, 5'b00010, 0, 1);
        applyStimulus(0, 0, 0, 3'd0); expectState("idle", 0, 1, 5'b00010, 0, 0);
        applyStimulus(0, 1, 1, 3'd4); expectState("ldadv", 0, 4, 5'b10000, 0, 0);

        // Asynchronous reset in the middle of an advance stream
        le[0] = 1'b0; ae[0] = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 expectState("async_rst", 0, 2, 5'b00100, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ae[0] = 1'b0;
        @(negedge clk);

        applyStimulus(1, 1, 0, 3'd0); expectState("m_ld0", 1, 0, 8'h80, 0, 0);
        applyStimulus(1, 0, 1, 3'd0); expectState("m_adv", 1, 1, 8'h40, 0, 0);
        applyStimulus(1, 1, 0, 3'd7); expectState("m_ld7", 1, 7, 8'h01, 0, 0);
        applyStimulus(1, 0, 1, 3'd0); expectState("m_wrap", 1, 0, 8'h80, 1, 0);
        applyStimulus(2, 0, 1, 3'd0); expectState("n2_wrap", 2, 0, 2'b01, 1, 0);

`ifdef IDX_OH_POINTER_MASK_EN
        applyStimulus(1, 1, 0, 3'd5); expectState("mk_ld5", 1, 5, 8'h04, 0, 0);
        mask[1] = 8'b0000_0110;
        applyStimulus(1, 0, 1, 3'd0); expectState("mk_adv", 1, 1, 8'h40, 1, 0);
        mask[1] = 8'h00;
        applyStimulus(1, 0, 1, 3'd0); expectState("mk_zero", 1, 1, 8'h40, 0, 0);
        mask[1] = 8'hFF;
`endif

        // Random mixed traffic on all instances at once
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < NINST; j++) begin
                le[j] = ($urandom_range(0, 3) == 0);
                ae[j] = ($urandom_range(0, 1) == 1);
                li[j] = 3'($urandom_range(0, 7));
`ifdef IDX_OH_POINTER_MASK_EN
                mask[j] = 8'($urandom_range(0, 255));
`endif
            end
            @(negedge clk);
        end
        for (int j = 0; j < NINST; j++) begin
            le[j] = 1'b0; ae[j] = 1'b0;
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
